// File: rtl/pattern_irq_ctrl_pkg.sv
// Shared definitions for the pattern-match interrupt controller: register map,
// bit positions and FSM state encoding.
package pattern_irq_ctrl_pkg;

  localparam logic [1:0] REG_PATTERN = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_FLAGS   = 2'd3;
  localparam logic [1:0] REG_MASK    = 2'd3;

  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_ONESHOT  = 1;
  localparam int unsigned FLAGS_OVERRUN = 0;
  localparam int unsigned FLAGS_PENDING = 1;
  localparam int unsigned ALIAS_OVERRUN = 7;
  localparam int unsigned ALIAS_PENDING = 6;

  localparam logic [1:0] ST_DISABLED = 2'b00;
  localparam logic [1:0] ST_ARMED    = 2'b01;
  localparam logic [1:0] ST_PENDING  = 2'b10;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == '1) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pattern_irq_regs.sv
// Register window decode, storage for PATTERN/CTRL (and MASK), registered read mux.
// Build option MATCH_MASK_EN: base+3 becomes MASK, flags alias into CTRL[7:6].
module pattern_irq_regs
  import pattern_irq_ctrl_pkg::*;
#(
  parameter logic [7:0] PORT_BASE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] match_count,
  input  logic       overrun,
  input  logic       pending,
  input  logic       enable_clr,
  output logic [7:0] pattern,
`ifdef MATCH_MASK_EN
  output logic [7:0] mask,
`endif
  output logic       enable,
  output logic       oneshot,
  output logic       ctrl_wr,
  output logic       status_wr,
  output logic       flags_rd,
  output logic [7:0] in_port
);

  logic [7:0] offset;
  logic       hit;
  logic [1:0] reg_sel;
  logic [7:0] ctrl_val;
  logic [7:0] rd_data;

  // Offset arithmetic wraps mod 256, so windows straddling 8'hFF still decode.
  assign offset  = port_id - PORT_BASE;
  assign hit     = (offset[7:2] == '0);
  assign reg_sel = offset[1:0];

  assign ctrl_wr   = write_strobe && hit && (reg_sel == REG_CTRL);
  assign status_wr = write_strobe && hit && (reg_sel == REG_STATUS);
`ifdef MATCH_MASK_EN
  assign flags_rd  = read_strobe && hit && (reg_sel == REG_CTRL);
`else
  assign flags_rd  = read_strobe && hit && (reg_sel == REG_FLAGS);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= '0;
      enable  <= 1'b0;
      oneshot <= 1'b0;
`ifdef MATCH_MASK_EN
      mask    <= '1;
`endif
    end else begin
      if (write_strobe && hit && (reg_sel == REG_PATTERN))
        pattern <= out_port;
`ifdef MATCH_MASK_EN
      if (write_strobe && hit && (reg_sel == REG_MASK))
        mask <= out_port;
`endif
      if (ctrl_wr) begin
        enable  <= out_port[CTRL_ENABLE];
        oneshot <= out_port[CTRL_ONESHOT];
      end
      if (enable_clr)
        enable <= 1'b0;
    end
  end

  always_comb begin
    ctrl_val               = '0;
    ctrl_val[CTRL_ENABLE]  = enable;
    ctrl_val[CTRL_ONESHOT] = oneshot;
`ifdef MATCH_MASK_EN
    ctrl_val[ALIAS_OVERRUN] = overrun;
    ctrl_val[ALIAS_PENDING] = pending;
`endif
    rd_data = '0;
    if (hit) begin
      case (reg_sel)
        REG_PATTERN: rd_data = pattern;
        REG_CTRL:    rd_data = ctrl_val;
        REG_STATUS:  rd_data = match_count;
        default: begin
`ifdef MATCH_MASK_EN
          rd_data = mask;
`else
          rd_data[FLAGS_OVERRUN] = overrun;
          rd_data[FLAGS_PENDING] = pending;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_port <= '0;
    else       in_port <= rd_data;
  end

endmodule

// File: rtl/pattern_irq_ctrl.sv
// Pattern-match interrupt controller: FSM, match counter and overrun flag.
// Build option MATCH_MASK_EN enables masked matching (see pattern_irq_regs).
module pattern_irq_ctrl
  import pattern_irq_ctrl_pkg::*;
#(
  parameter logic [7:0] PORT_BASE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  logic [1:0] state, state_next;
  logic [7:0] pattern;
`ifdef MATCH_MASK_EN
  logic [7:0] mask;
`endif
  logic       enable, oneshot;
  logic       ctrl_wr, status_wr, flags_rd;
  logic [7:0] match_count;
  logic       overrun;
  logic       match;
  logic       oneshot_clr;

  pattern_irq_regs #(.PORT_BASE(PORT_BASE)) u_regs (
    .clk         (clk),
    .reset       (reset),
    .port_id     (port_id),
    .out_port    (out_port),
    .write_strobe(write_strobe),
    .read_strobe (read_strobe),
    .match_count (match_count),
    .overrun     (overrun),
    .pending     (state == ST_PENDING),
    .enable_clr  (oneshot_clr),
    .pattern     (pattern),
`ifdef MATCH_MASK_EN
    .mask        (mask),
`endif
    .enable      (enable),
    .oneshot     (oneshot),
    .ctrl_wr     (ctrl_wr),
    .status_wr   (status_wr),
    .flags_rd    (flags_rd),
    .in_port     (in_port)
  );

  // Compares against the stored PATTERN, i.e. the pre-write value on a same-cycle write.
`ifdef MATCH_MASK_EN
  assign match = data_valid && (((data_in ^ pattern) & mask) == '0);
`else
  assign match = data_valid && (data_in == pattern);
`endif

  assign oneshot_clr = (state == ST_PENDING) && interrupt_ack && oneshot;

  always_comb begin
    state_next = state;
    case (state)
      ST_DISABLED: if (ctrl_wr && out_port[CTRL_ENABLE]) state_next = ST_ARMED;
      ST_ARMED:    if (match) state_next = ST_PENDING;
      ST_PENDING:  if (interrupt_ack) state_next = oneshot ? ST_DISABLED : ST_ARMED;
      default:     state_next = ST_DISABLED;
    endcase
    if (ctrl_wr && !out_port[CTRL_ENABLE])
      state_next = ST_DISABLED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_DISABLED;
      interrupt   <= 1'b0;
      match_count <= '0;
      overrun     <= 1'b0;
    end else begin
      state     <= state_next;
      interrupt <= (state_next == ST_PENDING);
      if (status_wr)
        match_count <= '0;
      else if (match && (state != ST_DISABLED))
        match_count <= sat_inc8(match_count);
      // A new overrun wins over a same-cycle FLAGS read so the event is not lost.
      if (match && (state == ST_PENDING))
        overrun <= 1'b1;
      else if (flags_rd)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_irq_ctrl.sv
// Self-checking bench for pattern_irq_ctrl: directed scenarios plus random traffic
// against a behavioural model. Honours MATCH_MASK_EN when defined.
module tb_pattern_irq_ctrl;

  localparam logic [7:0] BASE = 8'h40;
`ifdef MATCH_MASK_EN
  localparam int FLAGS_OFF = 1;
`else
  localparam int FLAGS_OFF = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id, out_port, in_port, data_in;
  logic       write_strobe, read_strobe, data_valid, interrupt, interrupt_ack;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit [7:0] m_pattern, m_mask, m_rd;
  bit       m_en, m_os, m_pend, m_ovr, m_irq;
  int       m_count;

  pattern_irq_ctrl #(.PORT_BASE(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int reg_off(input bit [7:0] pid);
    int off;
    off = int'(pid) - int'(BASE);
    return (off < 0 || off > 3) ? -1 : off;
  endfunction

  function automatic bit [7:0] model_read(input bit [7:0] pid);
    case (reg_off(pid))
      0: return m_pattern;
`ifdef MATCH_MASK_EN
      1: return {m_ovr, m_pend, 4'b0000, m_os, m_en};
      3: return m_mask;
`else
      1: return {6'b0, m_os, m_en};
      3: return {6'b0, m_pend, m_ovr};
`endif
      2: return m_count[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_pattern = 8'h00; m_mask = 8'hFF; m_rd = 8'h00;
    m_en = 0; m_os = 0; m_pend = 0; m_ovr = 0; m_irq = 0; m_count = 0;
  endtask

  task automatic model_step(input bit [7:0] pid, input bit [7:0] wd, input bit wr, input bit rd,
                            input bit [7:0] din, input bit dv, input bit ack);
    int off;
    bit match, old_en, old_os, old_pend;
    off      = reg_off(pid);
    m_rd     = model_read(pid);
`ifdef MATCH_MASK_EN
    match    = dv && (((din ^ m_pattern) & m_mask) == 8'h00);
`else
    match    = dv && (din == m_pattern);
`endif
    old_en   = m_en; old_os = m_os; old_pend = m_pend;
    if (wr && off == 2) m_count = 0;
    else if (match && old_en && m_count < 255) m_count++;
    if (match && old_pend) m_ovr = 1;
    else if (rd && off == FLAGS_OFF) m_ovr = 0;
    if (old_pend && ack) begin
      m_pend = 0;
      if (old_os) m_en = 0;
    end else if (old_en && !old_pend && match) begin
      m_pend = 1;
    end
    if (wr && off == 1) begin
      m_os = wd[1];
      if (!wd[0]) begin m_en = 0; m_pend = 0; end
      else if (!old_en) m_en = 1;
    end
    if (wr && off == 0) m_pattern = wd;
`ifdef MATCH_MASK_EN
    if (wr && off == 3) m_mask = wd;
`endif
    m_irq = m_pend;
  endtask

  // One clock cycle: drive inputs, step model on the edge, compare at negedge.
  task automatic tick(input bit [7:0] pid, input bit [7:0] wd, input bit wr, input bit rd,
                      input bit [7:0] din, input bit dv, input bit ack);
    port_id = pid; out_port = wd; write_strobe = wr; read_strobe = rd;
    data_in = din; data_valid = dv; interrupt_ack = ack;
    @(posedge clk);
    model_step(pid, wd, wr, rd, din, dv, ack);
    @(negedge clk);
    check("interrupt", interrupt, m_irq);
    check("in_port", in_port, m_rd);
  endtask

  task automatic wr_reg(input int off, input bit [7:0] v);
    tick(BASE + 8'(off), v, 1, 0, 8'h00, 0, 0);
  endtask

  task automatic rd_reg(input int off, output logic [7:0] v);
    tick(BASE + 8'(off), 8'h00, 0, 1, 8'h00, 0, 0);
    v = in_port;
  endtask

  task automatic drive(input bit [7:0] din, input bit dv, input bit ack);
    tick(8'h00, 8'h00, 0, 0, din, dv, ack);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    reset = 1'b1; port_id = '0; out_port = '0; write_strobe = 0; read_strobe = 0;
    data_in = '0; data_valid = 0; interrupt_ack = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_irq", interrupt, 1'b0);
    check("rst_in_port", in_port, 8'h00);
    reset = 1'b0;

    // basic match raises interrupt, count = 1
    wr_reg(0, 8'h5A);
    wr_reg(1, 8'h01);
    drive(8'h5A, 1, 0);
    check("match_irq", interrupt, 1'b1);
    rd_reg(2, v); check("count_one", v, 8'h01);

    // match while pending -> overrun, no re-raise after ack
    drive(8'h5A, 1, 0);
    drive(8'h00, 0, 1);
    check("ack_irq_low", interrupt, 1'b0);
    rd_reg(FLAGS_OFF, v);
`ifdef MATCH_MASK_EN
    check("flags_overrun", v, 8'h81);
`else
    check("flags_overrun", v, 8'h01);
`endif
    rd_reg(FLAGS_OFF, v);
`ifdef MATCH_MASK_EN
    check("flags_cleared", v, 8'h01);
`else
    check("flags_cleared", v, 8'h00);
`endif
    rd_reg(2, v); check("count_two", v, 8'h02);

    // oneshot: ack disables and clears ENABLE
    wr_reg(1, 8'h03);
    drive(8'h5A, 1, 0);
    check("oneshot_irq", interrupt, 1'b1);
    drive(8'h00, 0, 1);
    rd_reg(1, v); check("ctrl_after_oneshot", v, 8'h02);
    repeat (3) drive(8'h5A, 1, 0);
    check("disabled_no_irq", interrupt, 1'b0);
    rd_reg(2, v); check("count_frozen", v, 8'h03);

    // counter saturation and clear
    wr_reg(2, 8'h77);
    wr_reg(1, 8'h01);
    for (int i = 0; i < 256; i++) begin
      drive(8'h5A, 1, 0);
      drive(8'h00, 0, 1);
    end
    rd_reg(2, v); check("count_sat", v, 8'hFF);
    wr_reg(2, 8'h00);
    rd_reg(2, v); check("count_clear", v, 8'h00);

    // asynchronous reset while interrupt is high
    drive(8'h5A, 1, 0);
    check("pre_reset_irq", interrupt, 1'b1);
    #1 reset = 1'b1;
    #1 check("async_rst_irq", interrupt, 1'b0);
    check("async_rst_in_port", in_port, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int off = 0; off < 4; off++) begin
      rd_reg(off, v);
`ifdef MATCH_MASK_EN
      check("reset_regs", v, (off == 3) ? 8'hFF : 8'h00);
`else
      check("reset_regs", v, 8'h00);
`endif
    end

`ifdef MATCH_MASK_EN
    wr_reg(0, 8'hA0);
    wr_reg(3, 8'hF0);
    wr_reg(1, 8'h01);
    drive(8'hA7, 1, 0);
    check("mask_match_irq", interrupt, 1'b1);
    drive(8'h00, 0, 1);
    drive(8'hB0, 1, 0);
    check("mask_nomatch_irq", interrupt, 1'b0);
`endif

    // randomized traffic against the model
    wr_reg(0, 8'($urandom));
    wr_reg(1, 8'h01);
    for (int i = 0; i < 2000; i++) begin
      bit [7:0] pid, wd, din;
      bit wr, rd, dv, ack;
      pid = BASE - 8'd1 + 8'($urandom_range(0, 6));
      wr  = ($urandom_range(0, 99) < 15);
      rd  = ($urandom_range(0, 3) == 0);
      wd  = 8'($urandom);
      dv  = $urandom_range(0, 1) == 1;
      din = ($urandom_range(0, 1) == 1) ? m_pattern : 8'($urandom);
      ack = ($urandom_range(0, 9) < 3);
      tick(pid, wd, wr, rd, din, dv, ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
